// File: rtl/seg7_scan_display.sv
// -----------------------------------------------------------------------------
// seg7_scan_display
//
// Purpose:
//   Drives an 8-digit multiplexed seven-segment display with a 32-bit hex value.
//   The display is scanned one digit at a time. A new value is taken from the
//   CPU only at a frame boundary, so a frame never shows a mix of old and new
//   digits.
//
//   Scan timing:
//   - A prescaler produces one tick every CLK_DIV clocks.
//   - Each tick advances the digit slot.
//   - The advance from digit 7 back to digit 0 is the frame boundary.
//
//   Data path:
//   - load writes a shadow register and marks it pending.
//   - At a frame boundary, a pending shadow value moves into the display
//     register and ack pulses for one cycle.
//
// Parameters:
//   CLK_DIV  clock cycles per digit slot (2..1048575)
//
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   asynchronous active-high reset
//   load  in   data-valid strobe, sampled every cycle
//   data  in   32-bit value; digit i shows data[4i+3:4i]
//   an    out  active-low one-hot digit enables
//   seg   out  active-low segments, seg[0]=a .. seg[6]=g
//   dp    out  active-low decimal point, held off
//   ack   out  one-cycle pulse when a new value becomes the displayed value
//
// Build option:
//   LEADING_ZERO_BLANK_EN  when defined, digits above the most significant
//                          nonzero nibble are blanked. Digit 0 is always shown.
// -----------------------------------------------------------------------------
module seg7_scan_display #(
  parameter int CLK_DIV = 100000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] data,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        ack
);

  localparam logic [19:0] DIV_LAST = 20'(CLK_DIV - 1);

  logic [19:0] cnt;
  logic [2:0]  idx;
  logic [2:0]  idx_next;
  logic        tick;
  logic        frame_bnd;
  logic        take;
  logic [31:0] shadow;
  logic [31:0] display;
  logic [31:0] display_next;
  logic        pending;
  logic [3:0]  nibble;
  logic        blank;

  function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

`ifdef LEADING_ZERO_BLANK_EN
  // Index of the most significant nonzero nibble; 0 for an all-zero value.
  function automatic logic [2:0] top_digit(input logic [31:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (v[4*i +: 4] != 4'd0) r = 3'(i);
    end
    return r;
  endfunction
`endif

  assign tick      = (cnt == DIV_LAST);
  assign idx_next  = idx + 3'd1;
  assign frame_bnd = tick && (idx == 3'd7);
  assign take      = frame_bnd && pending;
  assign dp        = 1'b1;

  // The outputs for the new slot use the value the display register will hold
  // after this edge. A transfer at the boundary shows up on digit 0 at once.
  always_comb begin
    display_next = take ? shadow : display;
    nibble       = display_next[{idx_next, 2'b00} +: 4];
`ifdef LEADING_ZERO_BLANK_EN
    blank        = (idx_next > top_digit(display_next));
`else
    blank        = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= 3'd7;
      shadow  <= '0;
      display <= '0;
      pending <= 1'b0;
      ack     <= 1'b0;
      an      <= 8'hFF;
      seg     <= 7'h7F;
    end else begin
      cnt <= tick ? 20'd0 : cnt + 20'd1;
      ack <= take;

      // A load on the boundary edge leaves new data pending. The transfer on
      // that edge uses the shadow value from before the edge.
      if (load) begin
        shadow  <= data;
        pending <= 1'b1;
      end else if (take) begin
        pending <= 1'b0;
      end

      if (take) display <= shadow;

      if (tick) begin
        idx <= idx_next;
        if (blank) begin
          an  <= 8'hFF;
          seg <= 7'h7F;
        end else begin
          an  <= ~(8'd1 << idx_next);
          seg <= hex_to_seg(nibble);
        end
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_display.sv
module tb_seg7_scan_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [31:0] data;
  logic [7:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        ack;

  seg7_scan_display #(.CLK_DIV(DIV)) dut (
    .clk  (clk),
    .rst  (rst),
    .load (load),
    .data (data),
    .an   (an),
    .seg  (seg),
    .dp   (dp),
    .ack  (ack)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] SEG_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  int n_cmp = 0;
  int n_bad = 0;
  int ack_seen = 0;

  // Reference model, kept in terms of cycles, tick counts and transactions.
  int          m_cnt;
  int          m_ticks;
  logic [31:0] m_shadow;
  logic [31:0] m_disp;
  logic        m_pend;
  logic        m_ack;
  logic [7:0]  m_an;
  logic [6:0]  m_seg;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt    = 0;
    m_ticks  = 0;
    m_shadow = '0;
    m_disp   = '0;
    m_pend   = 1'b0;
    m_ack    = 1'b0;
    m_an     = 8'hFF;
    m_seg    = 7'h7F;
  endtask

  function automatic int highest_nonzero(input logic [31:0] v);
    int h;
    h = 0;
    for (int i = 0; i < 8; i++) if (((v >> (4 * i)) & 32'hF) != 0) h = i;
    return h;
  endfunction

  // One rising edge of the model, using the inputs seen before that edge.
  task automatic model_edge(input logic l, input logic [31:0] d);
    bit tick;
    bit bnd;
    int digit;
    if (rst) begin
      model_reset();
      return;
    end
    tick  = (m_cnt == DIV - 1);
    bnd   = tick && (m_ticks % 8 == 0);
    m_cnt = tick ? 0 : m_cnt + 1;
    m_ack = bnd && m_pend;
    if (bnd && m_pend) begin
      m_disp = m_shadow;
      m_pend = 1'b0;
    end
    if (l) begin
      m_shadow = d;
      m_pend   = 1'b1;
    end
    if (tick) begin
      digit = m_ticks % 8;
      m_ticks++;
`ifdef LEADING_ZERO_BLANK_EN
      if (digit > highest_nonzero(m_disp)) begin
        m_an  = 8'hFF;
        m_seg = 7'h7F;
      end else
`endif
      begin
        m_an  = ~(8'd1 << digit);
        m_seg = SEG_TAB[(m_disp >> (4 * digit)) & 32'hF];
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".an"},  {24'd0, an},  {24'd0, m_an});
    chk({tag, ".seg"}, {25'd0, seg}, {25'd0, m_seg});
    chk({tag, ".dp"},  {31'd0, dp},  32'd1);
    chk({tag, ".ack"}, {31'd0, ack}, {31'd0, m_ack});
  endtask

  // Drive inputs, take one clock edge, then check after the edge.
  task automatic step(input logic l, input logic [31:0] d, input string tag);
    load = l;
    data = d;
    @(posedge clk);
    model_edge(l, d);
    #1;
    load = 1'b0;
    if (ack === 1'b1) ack_seen++;
    check_outputs(tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, tag);
  endtask

  // Steps until the next edge is a frame boundary. The loop has a fixed bound.
  task automatic to_pre_boundary(input string tag);
    int guard;
    guard = 0;
    while (!(m_cnt == DIV - 1 && m_ticks % 8 == 0) && guard < 100) begin
      step(1'b0, 32'h0, tag);
      guard++;
    end
    chk({tag, ".reach_boundary"}, (guard < 100) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    model_reset();
    check_outputs({tag, ".async"});
    step(1'b0, 32'h0, {tag, ".held"});
    step(1'b0, 32'h0, {tag, ".held"});
    rst = 1'b0;
  endtask

  initial begin
    rst  = 1'b1;
    load = 1'b0;
    data = '0;
    model_reset();
    #2;
    check_outputs("reset0");
    @(posedge clk);
    #1;
    check_outputs("reset1");
    rst = 1'b0;

    // Reset release with no load: one full frame of zeros.
    idle(8 * DIV + 2, "first_frame");

    // A single load becomes visible at the next boundary, with exactly one ack.
    ack_seen = 0;
    step(1'b1, 32'h89ABCDEF, "load_89ab");
    idle(70, "show_89ab");
    chk("ack_count_89ab", ack_seen, 1);

    // Two mid-frame loads in a row: the last write wins, with a single ack.
    idle(5, "mid");
    ack_seen = 0;
    step(1'b1, 32'h1, "load_1");
    step(1'b1, 32'h2, "load_2");
    idle(70, "show_2");
    chk("ack_count_last_wins", ack_seen, 1);

    // A load on the boundary edge while 3 is pending: 3 then 5, two acks.
    idle(3, "pre3");
    ack_seen = 0;
    step(1'b1, 32'h3, "load_3");
    to_pre_boundary("wait_bnd");
    step(1'b1, 32'h5, "load_5_on_bnd");
    chk("ack_on_bnd", {31'd0, ack}, 32'd1);
    idle(70, "show_5");
    chk("ack_count_bnd", ack_seen, 2);

    // A reset mid-frame with data pending discards the data.
    idle(6, "pre_rst");
    step(1'b1, 32'h7777, "load_pend");
    idle(3, "pend");
    ack_seen = 0;
    do_reset("rst_mid");
    idle(70, "after_rst");
    chk("ack_count_after_rst", ack_seen, 0);

    // Leading-zero case.
    step(1'b1, 32'h00000A00, "load_a00");
    idle(70, "show_a00");
    step(1'b1, 32'h0, "load_zero");
    idle(70, "show_zero");

    // Randomized traffic, including occasional resets.
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset("rand_rst");
      end else begin
        logic [31:0] d;
        d = $urandom();
        d = d >> (4 * $urandom_range(0, 7));
        step($urandom_range(0, 15) == 0, d, "rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
